// File: rtl/uart_mem_host.sv
// -----------------------------------------------------------------------------
// uart_mem_host
//
// Initiator side of the UART memory-access protocol. A local command port
// accepts either a single-word write or an inclusive address-range read. The
// command is serialized, least-significant byte first, into UART byte frames:
//
//   write (8 bytes): 0x0F, addr lo, addr hi, {4'b0, wstrb}, wdata b0..b3
//   read  (5 bytes): 0xFF, end lo, end hi, start lo, start hi
//
// For reads the responder streams back 4 bytes per word; they are reassembled
// into 32-bit words and presented with their byte address on rd_*. A gap of
// TIMEOUT_CYCLES clk cycles between response bytes aborts the read with err.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (ready is high only while idle)
//   cmd_write         1 = write, 0 = read
//   cmd_addr          write address / read start address
//   cmd_addr_end      read end address (inclusive), ignored for writes
//   cmd_wstrb         byte enables, ignored for reads
//   cmd_wdata         write data, ignored for reads
//   tx_data/tx_start  byte and one-cycle launch pulse to the UART TX
//   tx_done           one-cycle pulse from the UART TX when a byte is sent
//   rx_data/rx_valid  received byte and its one-cycle valid pulse
//   rd_valid          one-cycle pulse with a reassembled word
//   rd_data/rd_addr   reassembled word and its address (held until next word)
//   done              one-cycle pulse when a command completes
//   err               one-cycle pulse when a read is rejected or times out
// -----------------------------------------------------------------------------
module uart_mem_host #(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_end,
  input  logic [3:0]            cmd_wstrb,
  input  logic [31:0]           cmd_wdata,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_done,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rd_valid,
  output logic [31:0]           rd_data,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  done,
  output logic                  err
);

  // Word counter is one bit narrower than the address: the largest possible
  // range (0x0000..0xFFFC for 16-bit addresses) holds 2^(ADDR_WIDTH-2) words.
  localparam int CNT_W  = ADDR_WIDTH - 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_TX,
    RECV,
    FIN,
    ERR
  } state_t;

  state_t                state_reg;
  logic [63:0]           frame_reg;       // outgoing frame, byte 0 in [7:0]
  logic [2:0]            byte_cnt_reg;    // frame bytes left after the current one
  logic                  is_write_reg;
  logic [ADDR_WIDTH-1:0] cur_addr_reg;    // address of the word being received
  logic [CNT_W-1:0]      words_left_reg;
  logic [1:0]            byte_idx_reg;    // byte position within current word
  logic [31:0]           word_reg;
  logic [IDLE_W-1:0]     idle_cnt_reg;

  logic                  cmd_ready_reg;
  logic [7:0]            tx_data_reg;
  logic                  tx_start_reg;
  logic                  rd_valid_reg;
  logic [31:0]           rd_data_reg;
  logic [ADDR_WIDTH-1:0] rd_addr_reg;
  logic                  done_reg;
  logic                  err_reg;

  assign cmd_ready = cmd_ready_reg;
  assign tx_data   = tx_data_reg;
  assign tx_start  = tx_start_reg;
  assign rd_valid  = rd_valid_reg;
  assign rd_data   = rd_data_reg;
  assign rd_addr   = rd_addr_reg;
  assign done      = done_reg;
  assign err       = err_reg;

  // ---------------------------------------------------------------------------
  // Frame construction from the live command inputs (latched on accept)
  // ---------------------------------------------------------------------------
  logic [15:0] addr_w;
  logic [15:0] end_w;
  logic [63:0] write_frame;
  logic [63:0] read_frame;

  // The wire always carries a 16-bit address field.
  assign addr_w = 16'(cmd_addr);
  assign end_w  = 16'(cmd_addr_end);

  assign write_frame[7:0]   = 8'h0F;
  assign write_frame[23:8]  = addr_w;
  assign write_frame[31:24] = {4'b0000, cmd_wstrb};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_wdata_bytes
      assign write_frame[32 + 8*gi +: 8] = cmd_wdata[8*gi +: 8];
    end
  endgenerate

  assign read_frame = {24'h000000, addr_w, end_w, 8'hFF};

  // ---------------------------------------------------------------------------
  // Read validation and word count, evaluated on the accepting cycle
  // ---------------------------------------------------------------------------
  logic                  rd_reject;
  logic [ADDR_WIDTH-1:0] span;
  logic [CNT_W-1:0]      n_words;

  assign rd_reject = !cmd_write &&
                     ((cmd_addr[1:0] != 2'b00) ||
                      (cmd_addr_end[1:0] != 2'b00) ||
                      (cmd_addr_end < cmd_addr));
  assign span      = cmd_addr_end - cmd_addr;
  assign n_words   = CNT_W'(span >> 2) + CNT_W'(1);

  // Incoming byte lands in the top of the word; after four bytes the first
  // received byte has walked down to [7:0].
  logic [31:0] word_shift;
  assign word_shift = {rx_data, word_reg[31:8]};

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      frame_reg      <= '0;
      byte_cnt_reg   <= '0;
      is_write_reg   <= 1'b0;
      cur_addr_reg   <= '0;
      words_left_reg <= '0;
      byte_idx_reg   <= '0;
      word_reg       <= '0;
      idle_cnt_reg   <= '0;
      cmd_ready_reg  <= 1'b1;
      tx_data_reg    <= '0;
      tx_start_reg   <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_data_reg    <= '0;
      rd_addr_reg    <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      tx_start_reg <= 1'b0;
      rd_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready_reg  <= 1'b0;
            is_write_reg   <= cmd_write;
            frame_reg      <= cmd_write ? write_frame : read_frame;
            byte_cnt_reg   <= cmd_write ? 3'd7 : 3'd4;
            cur_addr_reg   <= cmd_addr;
            words_left_reg <= n_words;
            byte_idx_reg   <= '0;
            word_reg       <= '0;
            idle_cnt_reg   <= '0;
            if (rd_reject) begin
              // err is raised on entry so it appears the cycle after accept.
              err_reg   <= 1'b1;
              state_reg <= ERR;
            end else begin
              state_reg <= LOAD;
            end
          end
        end

        LOAD: begin
          tx_data_reg  <= frame_reg[7:0];
          tx_start_reg <= 1'b1;
          state_reg    <= WAIT_TX;
        end

        WAIT_TX: begin
          if (tx_done) begin
            if (byte_cnt_reg != 3'd0) begin
              frame_reg    <= frame_reg >> 8;
              byte_cnt_reg <= byte_cnt_reg - 3'd1;
              state_reg    <= LOAD;
            end else if (is_write_reg) begin
              state_reg <= FIN;
            end else begin
              state_reg    <= RECV;
              idle_cnt_reg <= '0;
              // A response byte may already arrive on the very cycle the last
              // request byte completes; it is the first byte of word 0.
              if (rx_valid) begin
                word_reg     <= word_shift;
                byte_idx_reg <= 2'd1;
              end
            end
          end
        end

        RECV: begin
          if (rx_valid) begin
            idle_cnt_reg <= '0;
            word_reg     <= word_shift;
            byte_idx_reg <= byte_idx_reg + 2'd1;
            if (byte_idx_reg == 2'd3) begin
              rd_valid_reg   <= 1'b1;
              rd_data_reg    <= word_shift;
              rd_addr_reg    <= cur_addr_reg;
              cur_addr_reg   <= cur_addr_reg + ADDR_WIDTH'(4);
              words_left_reg <= words_left_reg - CNT_W'(1);
              if (words_left_reg == CNT_W'(1)) begin
                state_reg <= FIN;
              end
            end
          end else if (idle_cnt_reg == IDLE_LAST) begin
            // Responder went silent; any partial word is dropped.
            err_reg   <= 1'b1;
            state_reg <= ERR;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
          end
        end

        FIN: begin
          // One cycle after the final rd_valid (or final tx_done for writes).
          done_reg      <= 1'b1;
          cmd_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end

        ERR: begin
          cmd_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end

        default: begin
          cmd_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_mem_host.md
Name: uart_mem_host

Overview:
- Initiator side of the UART memory-access protocol: accepts single-word write or address-range read commands from a local command port and serializes them into UART byte frames.
- For reads, it collects the streamed response bytes and reassembles them into 32-bit words tagged with their addresses.
- Sits between a test or debug controller and a UART TX/RX pair. Used by on-board bring-up logic and by the system bench to drive the memory-access responder.

Parameters:
- ADDR_WIDTH, 16, width of byte addresses on the command port and on the wire.
- TIMEOUT_CYCLES, 1000000, maximum number of idle clk cycles allowed between response bytes before a read is aborted.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  write address, or read start address (ADDR_LOW).
- cmd_addr_end  input  ADDR_WIDTH  read end address, inclusive (ADDR_HIGH). Ignored for writes.
- cmd_wstrb  input  4  byte write enables. Ignored for reads.
- cmd_wdata  input  32  write data. Ignored for reads.
- tx_data  output  8  byte to transmit.
- tx_start  output  1  one-cycle pulse that launches tx_data.
- tx_done  input  1  one-cycle pulse when the UART TX has finished the current byte.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle pulse when rx_data is valid.
- rd_valid  output  1  one-cycle pulse when a reassembled read word is valid.
- rd_data  output  32  reassembled read word.
- rd_addr  output  ADDR_WIDTH  address of rd_data.
- done  output  1  one-cycle pulse when a command completes successfully.
- err  output  1  one-cycle pulse when a command is rejected or times out.

Behaviour:
- Reset: state IDLE; all outputs 0 except cmd_ready = 1; all counters and shift registers cleared. Asserting rst mid-operation abandons the transaction immediately; done and err are not pulsed.
- Wire frames, all multi-byte fields least-significant byte first:
  - Write, 8 bytes: 0x0F, addr[7:0], addr[15:8], {4'b0, wstrb}, wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24].
  - Read, 5 bytes: 0xFF, end[7:0], end[15:8], start[7:0], start[15:8].
- Acceptance: on the accepting cycle, all command fields are latched into a frame shift register and cmd_ready drops. Latched values are immune to later changes on the command inputs.
- Read validation at accept: the read is rejected if cmd_addr[1:0] != 0, cmd_addr_end[1:0] != 0, or cmd_addr_end < cmd_addr. On rejection, err pulses the next cycle, no bytes are sent, and the block returns to IDLE. Writes are never rejected; no alignment check is applied to writes.
- States:
  - IDLE: waits for cmd_valid. On acceptance goes to LOAD; on a rejected read goes to ERR.
  - LOAD: presents the next frame byte on tx_data and pulses tx_start for one cycle, then goes to WAIT_TX. The first tx_start occurs 1 cycle after acceptance.
  - WAIT_TX: waits for tx_done.
    - If frame bytes remain: shift the frame by 8 bits and return to LOAD.
    - Last byte of a write: go to FIN.
    - Last byte of a read: go to RECV.
    - tx_data holds its value until the next LOAD.
  - RECV: each rx_valid shifts rx_data into bits [31:24] of the word register while shifting existing bits down, so the first byte ends up in [7:0].
    - On the 4th byte: rd_valid pulses for one cycle, rd_data holds the full word, and rd_addr = start + 4*word_index.
    - rd_data and rd_addr are held until the next rd_valid.
    - After word count N = ((end - start) >> 2) + 1 words, go to FIN. N is computed at accept; the counter width is ADDR_WIDTH-1 bits.
  - FIN: done pulses for one cycle; return to IDLE.
  - ERR: err pulses for one cycle; return to IDLE.
- Timeout: in RECV, an idle counter resets on every rx_valid. When it reaches TIMEOUT_CYCLES, go to ERR, discarding any partial word.
- rx_valid is ignored outside RECV, including bytes that arrive during TX of a write.
- An rx_valid arriving in the same cycle as the transition into RECV is captured.
- tx_done outside WAIT_TX is ignored.
- rd_valid and done never pulse in the same cycle; done follows the last rd_valid by one cycle.
- Address arithmetic is modulo 2^ADDR_WIDTH. end = 0xFFFC with start = 0xFFFC yields exactly one word.

Test Plan:
- Write addr=0x0010, wstrb=0xF, wdata=0xDEADBEEF, tx_done returned 5 cycles after each tx_start -> tx bytes 0F 10 00 0F EF BE AD DE in order; one done pulse; no rd_valid.
- Read start=0x0100, end=0x0108; feed rx bytes 11 22 33 44 55 66 77 88 99 AA BB CC -> tx bytes FF 08 01 00 01; rd_valid three times with (0x0100, 0x44332211), (0x0104, 0x88776655), (0x0108, 0xCCBBAA99); done one cycle after the third rd_valid.
- Rejections: read start=0x0102 -> err pulse, zero tx_start. Read start=0x0200, end=0x01FC -> err pulse, zero tx_start.
- Timeout, with TIMEOUT_CYCLES=50: read one word, send 2 rx bytes, then silence -> err exactly 50 cycles after the last rx_valid; no rd_valid; cmd_ready high again.
- Reset mid-frame: assert rst after the 3rd tx_start of a write -> next cycle all outputs at reset values; no done/err; a following read completes normally.
- Spurious traffic: rx_valid pulses in IDLE and during write TX, plus a tx_done in IDLE -> no state change; the write frame bytes are unchanged.
